// File: rtl/soc_cluster_seq_pkg.sv
// Shared definitions for the cluster power sequencer.
//   cl_state_e  : per-cluster sequencing state, 3-bit encoding that is also
//                 driven on status_o.
//   cl_ctrl_t   : the five power/clock/reset control bits of one cluster.
//   CTRL_OFF    : control values while a cluster is off (and during reset).
//   ctrl_for()  : control values a cluster presents while in a given state.
//   max_int()   : helper for sizing the shared state counter.
package soc_cluster_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_PWR_UP = 3'd1,
      ST_CLK_ON = 3'd2,
      ST_BOOT   = 3'd3,
      ST_RUN    = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_ISO    = 3'd6,
      ST_PWR_DN = 3'd7
   } cl_state_e;

   typedef struct packed {
      logic pow;
      logic iso;
      logic clk_en;
      logic rstn;
      logic fetch_en;
   } cl_ctrl_t;

   localparam cl_ctrl_t CTRL_OFF = '{pow: 1'b0, iso: 1'b1, clk_en: 1'b0,
                                     rstn: 1'b0, fetch_en: 1'b0};

   function automatic cl_ctrl_t ctrl_for(input cl_state_e s);
      cl_ctrl_t c;
      c = CTRL_OFF;
      case (s)
         ST_PWR_UP: c = '{pow: 1'b1, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch_en: 1'b0};
         ST_CLK_ON: c = '{pow: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b0, fetch_en: 1'b0};
         ST_BOOT:   c = '{pow: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b1, fetch_en: 1'b0};
         ST_RUN:    c = '{pow: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b1, fetch_en: 1'b1};
         ST_DRAIN:  c = '{pow: 1'b1, iso: 1'b0, clk_en: 1'b1, rstn: 1'b1, fetch_en: 1'b0};
         ST_ISO:    c = '{pow: 1'b1, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch_en: 1'b0};
         ST_PWR_DN: c = '{pow: 1'b0, iso: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch_en: 1'b0};
         default:   c = CTRL_OFF;
      endcase
      return c;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/soc_cluster_seq_ch.sv
// Single-cluster power sequencer: FSM plus one shared cycle counter.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   pwr_on_req_i          level request (1 = cluster should be on)
//   boot_addr_i           boot address, captured only on OFF -> PWR_UP
//   pwr_ack_i             power-switch acknowledge (follows pow_o)
//   cluster_busy_i        cluster still active, delays shutdown
//   pow_o/iso_o/clk_en_o/rstn_o/fetch_en_o   registered control outputs
//   boot_addr_o           latched boot address
//   status_o              current state encoding
//   timeout_irq_o         one-cycle pulse when draining timed out
// Every output comes straight from a flop: on each transition the control
// bits for the destination state are loaded together with the state itself.
module soc_cluster_seq_ch
   import soc_cluster_seq_pkg::*;
#(
   parameter int BOOT_ADDR_WIDTH = 64,
   parameter int RST_CYCLES      = 8,
   parameter int DRAIN_TIMEOUT   = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       pwr_on_req_i,
   input  logic [BOOT_ADDR_WIDTH-1:0] boot_addr_i,
   input  logic                       pwr_ack_i,
   input  logic                       cluster_busy_i,
   output logic                       pow_o,
   output logic                       iso_o,
   output logic                       clk_en_o,
   output logic                       rstn_o,
   output logic                       fetch_en_o,
   output logic [BOOT_ADDR_WIDTH-1:0] boot_addr_o,
   output logic [2:0]                 status_o,
   output logic                       timeout_irq_o
);

   localparam int CNT_W = $clog2(max_int(RST_CYCLES, DRAIN_TIMEOUT) + 1);
   // Counter is cleared on state entry, so the last cycle of an N-cycle
   // dwell is reached when it reads N-1.
   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   cl_state_e                r_state;
   cl_ctrl_t                 r_ctrl;
   logic [CNT_W-1:0]         r_cnt;
   logic [BOOT_ADDR_WIDTH-1:0] r_boot_addr;
   logic                     r_irq;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_OFF;
         r_ctrl      <= CTRL_OFF;
         r_cnt       <= '0;
         r_boot_addr <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            ST_OFF: begin
               if (pwr_on_req_i) begin
                  r_state     <= ST_PWR_UP;
                  r_ctrl      <= ctrl_for(ST_PWR_UP);
                  r_cnt       <= '0;
                  r_boot_addr <= boot_addr_i;
               end
            end
            ST_PWR_UP: begin
               if (pwr_ack_i) begin
                  r_state <= ST_CLK_ON;
                  r_ctrl  <= ctrl_for(ST_CLK_ON);
                  r_cnt   <= '0;
               end
            end
            ST_CLK_ON: begin
               if (r_cnt == RST_LAST) begin
                  r_state <= ST_BOOT;
                  r_ctrl  <= ctrl_for(ST_BOOT);
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BOOT: begin
               r_state <= ST_RUN;
               r_ctrl  <= ctrl_for(ST_RUN);
               r_cnt   <= '0;
            end
            ST_RUN: begin
               if (!pwr_on_req_i) begin
                  r_state <= ST_DRAIN;
                  r_ctrl  <= ctrl_for(ST_DRAIN);
                  r_cnt   <= '0;
               end
            end
            ST_DRAIN: begin
               // An idle cluster always wins over the timeout on the same cycle.
               if (!cluster_busy_i) begin
                  r_state <= ST_ISO;
                  r_ctrl  <= ctrl_for(ST_ISO);
                  r_cnt   <= '0;
               end else if (r_cnt == DRAIN_LAST) begin
                  r_state <= ST_ISO;
                  r_ctrl  <= ctrl_for(ST_ISO);
                  r_cnt   <= '0;
                  r_irq   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ISO: begin
               r_state <= ST_PWR_DN;
               r_ctrl  <= ctrl_for(ST_PWR_DN);
               r_cnt   <= '0;
            end
            ST_PWR_DN: begin
               if (!pwr_ack_i) begin
                  r_state <= ST_OFF;
                  r_ctrl  <= CTRL_OFF;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= ST_OFF;
               r_ctrl  <= CTRL_OFF;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign pow_o         = r_ctrl.pow;
   assign iso_o         = r_ctrl.iso;
   assign clk_en_o      = r_ctrl.clk_en;
   assign rstn_o        = r_ctrl.rstn;
   assign fetch_en_o    = r_ctrl.fetch_en;
   assign boot_addr_o   = r_boot_addr;
   assign status_o      = r_state;
   assign timeout_irq_o = r_irq;

endmodule

// File: rtl/soc_cluster_seq.sv
// Multi-cluster power sequencer: N_CLUSTERS independent copies of the
// single-cluster sequencer, with per-cluster signals packed side by side
// (cluster c occupies bit c, or slice [c*W +: W] for wide fields).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   pwr_on_req_i          per-cluster on/off level request
//   boot_addr_i           per-cluster boot address
//   pwr_ack_i             per-cluster power-switch acknowledge
//   cluster_busy_i        per-cluster activity flag
//   cluster_pow_o, cluster_iso_o, cluster_clk_en_o, cluster_rstn_o,
//   cluster_fetch_en_o    per-cluster control outputs
//   cluster_boot_addr_o   per-cluster latched boot address
//   status_o              per-cluster 3-bit state
//   timeout_irq_o         per-cluster drain-timeout pulse
module soc_cluster_seq
   import soc_cluster_seq_pkg::*;
#(
   parameter int N_CLUSTERS      = 2,
   parameter int BOOT_ADDR_WIDTH = 64,
   parameter int RST_CYCLES      = 8,
   parameter int DRAIN_TIMEOUT   = 1024
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [N_CLUSTERS-1:0]                 pwr_on_req_i,
   input  logic [N_CLUSTERS*BOOT_ADDR_WIDTH-1:0] boot_addr_i,
   input  logic [N_CLUSTERS-1:0]                 pwr_ack_i,
   input  logic [N_CLUSTERS-1:0]                 cluster_busy_i,
   output logic [N_CLUSTERS-1:0]                 cluster_pow_o,
   output logic [N_CLUSTERS-1:0]                 cluster_iso_o,
   output logic [N_CLUSTERS-1:0]                 cluster_clk_en_o,
   output logic [N_CLUSTERS-1:0]                 cluster_rstn_o,
   output logic [N_CLUSTERS-1:0]                 cluster_fetch_en_o,
   output logic [N_CLUSTERS*BOOT_ADDR_WIDTH-1:0] cluster_boot_addr_o,
   output logic [N_CLUSTERS*3-1:0]               status_o,
   output logic [N_CLUSTERS-1:0]                 timeout_irq_o
);

   for (genvar g = 0; g < N_CLUSTERS; g++) begin : g_cluster
      soc_cluster_seq_ch #(
         .BOOT_ADDR_WIDTH (BOOT_ADDR_WIDTH),
         .RST_CYCLES      (RST_CYCLES),
         .DRAIN_TIMEOUT   (DRAIN_TIMEOUT)
      ) u_ch (
         .clk_i          (clk_i),
         .rst_i          (rst_i),
         .pwr_on_req_i   (pwr_on_req_i[g]),
         .boot_addr_i    (boot_addr_i[g*BOOT_ADDR_WIDTH +: BOOT_ADDR_WIDTH]),
         .pwr_ack_i      (pwr_ack_i[g]),
         .cluster_busy_i (cluster_busy_i[g]),
         .pow_o          (cluster_pow_o[g]),
         .iso_o          (cluster_iso_o[g]),
         .clk_en_o       (cluster_clk_en_o[g]),
         .rstn_o         (cluster_rstn_o[g]),
         .fetch_en_o     (cluster_fetch_en_o[g]),
         .boot_addr_o    (cluster_boot_addr_o[g*BOOT_ADDR_WIDTH +: BOOT_ADDR_WIDTH]),
         .status_o       (status_o[g*3 +: 3]),
         .timeout_irq_o  (timeout_irq_o[g])
      );
   end

endmodule

// File: tb/tb_soc_cluster_seq.sv
// Bench for soc_cluster_seq. A reference model steps once per rising edge
// from the sampled inputs and queues the full expected output picture; a
// monitor on the falling edge pops and compares it against the DUT.
// Inputs change only on the falling edge (reset may also rise mid-cycle).
module tb_soc_cluster_seq;

   localparam int N    = 2;
   localparam int AW   = 64;
   localparam int RSTC = 8;
   localparam int DT   = 16;
   localparam int CW   = 5 + 3 + 1 + AW;
   localparam int EW   = N * CW;

   // clock / reset
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic [N-1:0]    pwr_on_req_i;
   logic [N*AW-1:0] boot_addr_i;
   logic [N-1:0]    pwr_ack_i = '0;
   logic [N-1:0]    cluster_busy_i;
   logic [N-1:0]    cluster_pow_o, cluster_iso_o, cluster_clk_en_o;
   logic [N-1:0]    cluster_rstn_o, cluster_fetch_en_o, timeout_irq_o;
   logic [N*AW-1:0] cluster_boot_addr_o;
   logic [N*3-1:0]  status_o;

   soc_cluster_seq #(
      .N_CLUSTERS(N), .BOOT_ADDR_WIDTH(AW), .RST_CYCLES(RSTC), .DRAIN_TIMEOUT(DT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pwr_on_req_i(pwr_on_req_i),
      .boot_addr_i(boot_addr_i), .pwr_ack_i(pwr_ack_i),
      .cluster_busy_i(cluster_busy_i), .cluster_pow_o(cluster_pow_o),
      .cluster_iso_o(cluster_iso_o), .cluster_clk_en_o(cluster_clk_en_o),
      .cluster_rstn_o(cluster_rstn_o), .cluster_fetch_en_o(cluster_fetch_en_o),
      .cluster_boot_addr_o(cluster_boot_addr_o), .status_o(status_o),
      .timeout_irq_o(timeout_irq_o)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
      end
   endfunction

   // ---------------- reference model ----------------
   // Phase numbers are the status codes; controls {pow,iso,clk_en,rstn,fetch}.
   int             m_ph[N];
   int             m_dw[N];
   logic [AW-1:0]  m_ba[N];
   logic           m_irq[N];
   logic [EW-1:0]  exp_q[$];

   function automatic logic [4:0] ctl_of(input int ph);
      case (ph)
         1:       return 5'b11000;
         2:       return 5'b10100;
         3:       return 5'b10110;
         4:       return 5'b10111;
         5:       return 5'b10110;
         6:       return 5'b11000;
         default: return 5'b01000;
      endcase
   endfunction

   function automatic logic [EW-1:0] model_vec();
      logic [EW-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++)
         v[c*CW +: CW] = {ctl_of(m_ph[c]), 3'(m_ph[c]), m_irq[c], m_ba[c]};
      return v;
   endfunction

   function automatic logic [EW-1:0] dut_vec();
      logic [EW-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++)
         v[c*CW +: CW] = {cluster_pow_o[c], cluster_iso_o[c], cluster_clk_en_o[c],
                          cluster_rstn_o[c], cluster_fetch_en_o[c], status_o[c*3 +: 3],
                          timeout_irq_o[c], cluster_boot_addr_o[c*AW +: AW]};
      return v;
   endfunction

   always @(posedge clk_i) begin
      for (int c = 0; c < N; c++) begin
         int nph;
         if (rst_i) begin
            m_ph[c] = 0; m_dw[c] = 0; m_ba[c] = '0; m_irq[c] = 1'b0;
         end else begin
            nph = m_ph[c];
            m_irq[c] = 1'b0;
            case (m_ph[c])
               0: if (pwr_on_req_i[c]) begin nph = 1; m_ba[c] = boot_addr_i[c*AW +: AW]; end
               1: if (pwr_ack_i[c]) nph = 2;
               2: begin m_dw[c]++; if (m_dw[c] == RSTC) nph = 3; end
               3: nph = 4;
               4: if (!pwr_on_req_i[c]) nph = 5;
               5: begin
                  m_dw[c]++;
                  if (!cluster_busy_i[c]) nph = 6;
                  else if (m_dw[c] == DT) begin nph = 6; m_irq[c] = 1'b1; end
               end
               6: nph = 7;
               7: if (!pwr_ack_i[c]) nph = 0;
               default: nph = 0;
            endcase
            if (nph != m_ph[c]) begin m_ph[c] = nph; m_dw[c] = 0; end
         end
      end
      exp_q.push_back(model_vec());
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk_i) begin
      logic [EW-1:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL cycle_vector: no expected entry at t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (dut_vec() !== e) begin
            n_err++;
            if (n_err < 20)
               $display("FAIL cycle_vector t=%0t got %h required %h", $time, dut_vec(), e);
         end
      end
   end

   // ---------------- power-switch ack driver ----------------
   int ack_w[N];
   int ack_d[N];
   bit ack_fixed = 1'b1;
   initial for (int c = 0; c < N; c++) begin ack_w[c] = 0; ack_d[c] = 3; end

   always @(negedge clk_i) begin
      for (int c = 0; c < N; c++) begin
         if (pwr_ack_i[c] != cluster_pow_o[c]) begin
            if (ack_w[c] >= ack_d[c]) begin
               pwr_ack_i[c] = cluster_pow_o[c];
               ack_w[c] = 0;
               ack_d[c] = ack_fixed ? 3 : int'($urandom_range(0, 4));
            end else begin
               ack_w[c]++;
            end
         end else begin
            ack_w[c] = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_status(input int c, input logic [2:0] st, input string nm);
      for (int k = 0; k < 200; k++) begin
         if (status_o[c*3 +: 3] == st) break;
         @(negedge clk_i);
      end
      chk(nm, 64'(status_o[c*3 +: 3]), 64'(st));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int off_cnt;
      rst_i = 1'b1; pwr_on_req_i = '0; cluster_busy_i = '0; boot_addr_i = '0;
      repeat (3) @(negedge clk_i);
      chk("reset_status", 64'(status_o), 64'd0);
      chk("reset_iso", 64'(cluster_iso_o), 64'({N{1'b1}}));
      chk("reset_boot_addr", cluster_boot_addr_o[63:0], 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // power-up latency, boot address captured only at the request edge
      boot_addr_i[63:0] = 64'h1C008080;
      pwr_on_req_i[0] = 1'b1;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk_i); n++;
         @(negedge clk_i);
         if (k == 0) boot_addr_i[63:0] = {$urandom(), $urandom()};
         if (cluster_fetch_en_o[0]) break;
      end
      chk("pwrup_latency", 64'(n), 64'd14);
      chk("pwrup_boot_addr", cluster_boot_addr_o[63:0], 64'h1C008080);

      // clean shutdown
      cluster_busy_i[0] = 1'b0; pwr_on_req_i[0] = 1'b0;
      @(negedge clk_i);
      chk("shut_fetch", 64'(cluster_fetch_en_o[0]), 64'd0);
      @(negedge clk_i);
      chk("shut_iso", 64'(cluster_iso_o[0]), 64'd1);
      @(negedge clk_i);
      chk("shut_pow", 64'(cluster_pow_o[0]), 64'd0);
      wait_status(0, 3'd0, "shut_off");

      // drain timeout with busy stuck high
      pwr_on_req_i[0] = 1'b1;
      wait_status(0, 3'd4, "to_run");
      cluster_busy_i[0] = 1'b1; pwr_on_req_i[0] = 1'b0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk_i); n++;
         @(negedge clk_i);
         if (timeout_irq_o[0]) break;
      end
      chk("timeout_latency", 64'(n), 64'(DT + 1));
      chk("timeout_state", 64'(status_o[2:0]), 64'd6);
      @(negedge clk_i);
      chk("timeout_one_pulse", 64'(timeout_irq_o[0]), 64'd0);
      cluster_busy_i[0] = 1'b0;

      // re-request during power-down
      wait_status(0, 3'd7, "to_pwr_dn");
      pwr_on_req_i[0] = 1'b1;
      boot_addr_i[63:0] = 64'hA5A5_0000_1234_5678;
      off_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         if (status_o[2:0] == 3'd0) off_cnt++;
         if (status_o[2:0] == 3'd4) break;
      end
      chk("rereq_off_cycles", 64'(off_cnt), 64'd1);
      chk("rereq_boot_addr", cluster_boot_addr_o[63:0], 64'hA5A5_0000_1234_5678);

      // asynchronous reset with cluster 0 running and cluster 1 in CLK_ON
      pwr_on_req_i[1] = 1'b1;
      wait_status(1, 3'd2, "c1_clk_on");
      chk("c0_still_run", 64'(status_o[2:0]), 64'd4);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_status", 64'(status_o), 64'd0);
      chk("arst_ctrl", 64'({cluster_pow_o, cluster_iso_o, cluster_clk_en_o,
                             cluster_rstn_o, cluster_fetch_en_o, timeout_irq_o}),
          64'({{N{1'b0}}, {N{1'b1}}, {(4*N){1'b0}}}));
      chk("arst_boot_addr", 64'(|cluster_boot_addr_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0; pwr_on_req_i = '0;

      // randomized traffic on both clusters
      ack_fixed = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk_i);
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 39) == 0) pwr_on_req_i[c] = ~pwr_on_req_i[c];
            if ($urandom_range(0, 7) == 0) cluster_busy_i[c] = ($urandom_range(0, 3) != 0);
            boot_addr_i[c*AW +: AW] = {$urandom(), $urandom()};
         end
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
         end
      end
      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/soc_cluster_seq.md
SOC_CLUSTER_SEQ -- requirements
Module: soc_cluster_seq

Interface
REQ-001 SHALL have parameter N_CLUSTERS, default 2: number of independently sequenced clusters (1..8).
REQ-002 SHALL have parameter BOOT_ADDR_WIDTH, default 64: width of each boot address.
REQ-003 SHALL have parameter RST_CYCLES, default 8: cycles cluster reset is held after clock enable (>=1).
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1024: maximum cycles spent waiting for busy to drop (>=1).
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pwr_on_req_i  input  N_CLUSTERS  level request: 1 = cluster on, 0 = cluster off.
REQ-008 SHALL have port boot_addr_i  input  N_CLUSTERS x BOOT_ADDR_WIDTH  per-cluster boot address.
REQ-009 SHALL have port pwr_ack_i  input  N_CLUSTERS  power-switch acknowledge, follows cluster_pow_o.
REQ-010 SHALL have port cluster_busy_i  input  N_CLUSTERS  cluster activity flag.
REQ-011 SHALL have port cluster_pow_o  output  N_CLUSTERS  power-switch enable.
REQ-012 SHALL have port cluster_iso_o  output  N_CLUSTERS  isolation enable, 1 = isolated.
REQ-013 SHALL have port cluster_clk_en_o  output  N_CLUSTERS  clock-gate enable.
REQ-014 SHALL have port cluster_rstn_o  output  N_CLUSTERS  cluster reset, active-low.
REQ-015 SHALL have port cluster_fetch_en_o  output  N_CLUSTERS  core fetch enable.
REQ-016 SHALL have port cluster_boot_addr_o  output  N_CLUSTERS x BOOT_ADDR_WIDTH  latched boot address.
REQ-017 SHALL have port status_o  output  N_CLUSTERS x 3  current state encoding per cluster.
REQ-018 SHALL have port timeout_irq_o  output  N_CLUSTERS  one-cycle pulse on drain timeout.

Function
REQ-019 Each cluster SHALL run an independent FSM: OFF=0, PWR_UP=1, CLK_ON=2, BOOT=3, RUN=4, DRAIN=5, ISO=6, PWR_DN=7; status_o = state.
REQ-020 OFF: all outputs at reset values; pwr_on_req_i=1 -> PWR_UP, boot_addr_i latched into cluster_boot_addr_o on the same edge.
REQ-021 PWR_UP: pow=1, iso=1; pwr_ack_i=1 -> CLK_ON.
REQ-022 CLK_ON: pow=1, clk_en=1, iso=0, rstn=0; counter runs RST_CYCLES cycles, then -> BOOT.
REQ-023 BOOT: rstn=1, fetch_en=0 for exactly one cycle, then -> RUN.
REQ-024 RUN: rstn=1, fetch_en=1; pwr_on_req_i=0 -> DRAIN.
REQ-025 DRAIN: fetch_en=0, rstn=1, clk_en=1; cluster_busy_i=0 -> ISO; else after DRAIN_TIMEOUT cycles -> ISO with timeout_irq_o=1 for one cycle.
REQ-026 ISO: iso=1, clk_en=0, rstn=0, pow=1 for one cycle, then -> PWR_DN.
REQ-027 PWR_DN: pow=0, iso=1; pwr_ack_i=0 -> OFF.
REQ-028 Request deasserted in PWR_UP/CLK_ON/BOOT SHALL not abort; sequence completes to RUN, then evaluates REQ-024.
REQ-029 Request reasserted in DRAIN/ISO/PWR_DN SHALL not abort; shutdown completes to OFF, then restarts from OFF.
REQ-030 boot_addr_i changes outside the OFF->PWR_UP edge SHALL not affect cluster_boot_addr_o.
REQ-031 Counters SHALL be sized $clog2(max(RST_CYCLES,DRAIN_TIMEOUT)+1) and cleared on every state entry.
REQ-032 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-033 rst_i asserted SHALL immediately force every cluster to OFF, including mid-sequence: pow=0, iso=1, clk_en=0, rstn=0, fetch_en=0, boot_addr=0, status=0, timeout_irq=0, counters=0.

Structure
REQ-034 State enum, its 3-bit encoding and the off-state output defaults SHALL live in package soc_cluster_seq_pkg.
REQ-035 One sub-module soc_cluster_seq_ch (single-cluster FSM plus counter) SHALL be instantiated N_CLUSTERS times via generate.

Verification
REQ-036 Power-up: req[0]=1 at cycle 0, ack after 3 cycles, boot_addr=0x1C008080 -> fetch_en[0]=1 exactly 1+3+1+RST_CYCLES(8)+1 cycles after request seen, boot_addr_o=0x1C008080.
REQ-037 Clean shutdown: in RUN, req=0, busy=0 -> fetch_en=0 next cycle, iso=1 two cycles later, pow=0 one cycle after that, status=0 after ack drops.
REQ-038 Drain timeout: busy held 1, DRAIN_TIMEOUT=16 -> timeout_irq pulses once after 16 DRAIN cycles, FSM reaches ISO.
REQ-039 Re-request: req 1->0->1 during PWR_DN -> passes through OFF for one cycle, then full power-up with newly latched boot address.
REQ-040 Independence/reset: cluster 0 in RUN, cluster 1 in CLK_ON, rst_i pulsed mid-cycle -> both clusters' outputs at reset values before the next clock edge.
